ibex_bloom_unit: RTL and testbench



---
 rtl/ibex_bloom_pkg.sv | 26 ++
 rtl/ibex_bloom_hash.sv | 21 ++
 rtl/ibex_bloom_unit.sv | 156 +++++++++++++++
 tb/tb_ibex_bloom_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_bloom_pkg.sv
// Shared types and hash seeds for the Bloom-filter coprocessor.
// The hash uses a multiplicative scheme: key times an odd seed, keeping the top bits.
package ibex_bloom_pkg;

    typedef enum logic [1:0] {
        BLOOM_INSERT = 2'b00,
        BLOOM_CHECK  = 2'b01,
        BLOOM_CLEAR  = 2'b10,
        BLOOM_RSVD   = 2'b11
    } bloom_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HASH,
        ST_CLEAR,
        ST_RESP
    } bloom_state_e;

    localparam int unsigned MaxHashes = 8;

    localparam logic [31:0] BLOOM_SEED [MaxHashes] = '{
        32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F,
        32'h165667B1, 32'hD3A2646D, 32'hFD7046C5, 32'hB55A4F09
    };

endpackage

// File: rtl/ibex_bloom_hash.sv
// Combinational multiplicative hash: one instance is shared by all hash functions,
// with sel_i choosing the seed for the current hash step.
module ibex_bloom_hash
    import ibex_bloom_pkg::*;
#(
    parameter int unsigned NumBits = 1024
) (
    input  logic [31:0]                key_i,
    input  logic [2:0]                 sel_i,
    output logic [$clog2(NumBits)-1:0] idx_o
);

    localparam int unsigned IdxW = $clog2(NumBits);

    logic [31:0] prod;

    // Only the low 32 bits of the product are kept; the index is their top IdxW bits.
    assign prod  = key_i * BLOOM_SEED[sel_i];
    assign idx_o = prod[31 -: IdxW];

endmodule

// File: rtl/ibex_bloom_unit.sv
// Multi-cycle Bloom-filter coprocessor on the EX-stage custom-instruction interface.
// It hashes one index per cycle to INSERT or CHECK, and zeroes one chunk per cycle to CLEAR.
module ibex_bloom_unit
    import ibex_bloom_pkg::*;
#(
    parameter int unsigned NumBits           = 1024,
    parameter int unsigned NumHashes         = 3,
    parameter int unsigned ClearBitsPerCycle = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_key_i,
    input  logic [31:0] req_salt_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [15:0] insert_count_o
);

    localparam int unsigned IdxW      = $clog2(NumBits);
    localparam int unsigned NumChunks = NumBits / ClearBitsPerCycle;
    localparam int unsigned MaxCnt    = (NumChunks > NumHashes) ? NumChunks : NumHashes;
    localparam int unsigned CntW      = ($clog2(MaxCnt) < 3) ? 3 : $clog2(MaxCnt);

    bloom_state_e         state_q, state_d;
    bloom_op_e            op_q, op_d;
    logic [31:0]          key_q, key_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 hit_q, hit_d;
    logic                 err_q, err_d;
    logic [NumBits-1:0]   bits_q, bits_d;
    logic [15:0]          ins_cnt_q, ins_cnt_d;

    logic                 accept;
    logic                 last_hash;
    logic                 last_chunk;
    logic [IdxW-1:0]      idx;
    bloom_op_e            req_op;

    assign req_op     = bloom_op_e'(req_op_i);
    assign accept     = req_valid_i && (state_q == ST_IDLE);
    assign last_hash  = (cnt_q == CntW'(NumHashes - 1));
    assign last_chunk = (cnt_q == CntW'(NumChunks - 1));

    ibex_bloom_hash #(
        .NumBits (NumBits)
    ) u_hash (
        .key_i (key_q),
        .sel_i (cnt_q[2:0]),
        .idx_o (idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (req_op)
                        BLOOM_INSERT, BLOOM_CHECK: state_d = ST_HASH;
                        BLOOM_CLEAR:               state_d = ST_CLEAR;
                        default:                   state_d = ST_RESP;
                    endcase
                end
            end
            ST_HASH:  if (last_hash)   state_d = ST_RESP;
            ST_CLEAR: if (last_chunk)  state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = (state_q == ST_IDLE);
        busy_o         = (state_q != ST_IDLE);
        rsp_valid_o    = (state_q == ST_RESP);
        rsp_result_o   = {31'b0, hit_q & rsp_valid_o};
        rsp_err_o      = err_q & rsp_valid_o;
        insert_count_o = ins_cnt_q;
    end

    always_comb begin
        op_d      = op_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        err_d     = err_q;
        bits_d    = bits_q;
        ins_cnt_d = ins_cnt_q;

        if (accept) begin
            op_d  = req_op;
            key_d = req_key_i ^ req_salt_i;
            cnt_d = '0;
            hit_d = (req_op == BLOOM_INSERT) || (req_op == BLOOM_CHECK);
            err_d = (req_op == BLOOM_RSVD);
        end

        if (state_q == ST_HASH) begin
            // The read sees bits_q, so this hash's own set is not visible until the next step.
            hit_d = hit_q & bits_q[idx];
            if (op_q == BLOOM_INSERT) begin
                bits_d[idx] = 1'b1;
            end
            cnt_d = last_hash ? '0 : cnt_q + 1'b1;
            if (last_hash && (op_q == BLOOM_INSERT) && (ins_cnt_q != 16'hFFFF)) begin
                ins_cnt_d = ins_cnt_q + 16'd1;
            end
        end

        if (state_q == ST_CLEAR) begin
            bits_d[int'(cnt_q) * ClearBitsPerCycle +: ClearBitsPerCycle] = '0;
            cnt_d = last_chunk ? '0 : cnt_q + 1'b1;
            if (last_chunk) begin
                hit_d     = 1'b0;
                ins_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= BLOOM_INSERT;
            key_q     <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
            // NOTE: the filter array is reset because a reset must leave no trace of earlier keys.
            bits_q    <= '0;
            ins_cnt_q <= '0;
        end else begin
            op_q      <= op_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
            bits_q    <= bits_d;
            ins_cnt_q <= ins_cnt_d;
        end
    end

endmodule

// File: tb/tb_ibex_bloom_unit.sv
// Directed bench for ibex_bloom_unit: latency, hit results, counters, hold behaviour, reset.
module tb_ibex_bloom_unit;
    import ibex_bloom_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = 2'b00;
    logic [31:0] req_key_i = '0;
    logic [31:0] req_salt_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_result_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic [15:0] insert_count_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    ibex_bloom_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_key_i      (req_key_i),
        .req_salt_i     (req_salt_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_result_o   (rsp_result_o),
        .rsp_err_o      (rsp_err_o),
        .busy_o         (busy_o),
        .insert_count_o (insert_count_o)
    );

    // Issue one request and wait (bounded) for rsp_valid_o; the accept cycle is cycle 0.
    task automatic issue(input logic [1:0] op, input logic [31:0] key, input logic [31:0] salt,
                         output int lat, output logic [31:0] res, output logic err);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_key_i   = key;
        req_salt_i  = salt;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        res = rsp_result_o;
        err = rsp_err_o;
    endtask

    task automatic finish_rsp();
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] key, input logic [31:0] salt,
                         output int lat, output logic [31:0] res, output logic err);
        issue(op, key, salt, lat, res, err);
        finish_rsp();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (req_ready_o !== 1'b1)  begin n_fails++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
        n_checks++; if (rsp_valid_o !== 1'b0)  begin n_fails++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid_o); end
        n_checks++; if (rsp_result_o !== 32'h0) begin n_fails++; $display("FAIL reset_result: got %h exp 0", rsp_result_o); end
        n_checks++; if (rsp_err_o !== 1'b0)    begin n_fails++; $display("FAIL reset_err: got %b exp 0", rsp_err_o); end
        n_checks++; if (busy_o !== 1'b0)       begin n_fails++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
        n_checks++; if (insert_count_o !== 16'h0) begin n_fails++; $display("FAIL reset_count: got %h exp 0", insert_count_o); end
    endtask

    task automatic test_check_empty();
        int lat; logic [31:0] res; logic err;
        issue(BLOOM_CHECK, 32'h12345678, 32'h0, lat, res, err);
        n_checks++; if (busy_o !== 1'b1) begin n_fails++; $display("FAIL chk_empty_busy: got %b exp 1", busy_o); end
        finish_rsp();
        n_checks++; if (lat !== 4)        begin n_fails++; $display("FAIL chk_empty_latency: got %0d exp 4", lat); end
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL chk_empty_result: got %h exp 0", res); end
        n_checks++; if (err !== 1'b0)     begin n_fails++; $display("FAIL chk_empty_err: got %b exp 0", err); end
        n_checks++; if (insert_count_o !== 16'd0) begin n_fails++; $display("FAIL chk_empty_count: got %0d exp 0", insert_count_o); end
    endtask

    task automatic test_insert();
        int lat; logic [31:0] res; logic err;
        do_op(BLOOM_INSERT, 32'h12345678, 32'h0, lat, res, err);
        n_checks++; if (lat !== 4)        begin n_fails++; $display("FAIL ins1_latency: got %0d exp 4", lat); end
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL ins1_result: got %h exp 0", res); end
        n_checks++; if (insert_count_o !== 16'd1) begin n_fails++; $display("FAIL ins1_count: got %0d exp 1", insert_count_o); end
        do_op(BLOOM_INSERT, 32'h12345678, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h1)    begin n_fails++; $display("FAIL ins2_result: got %h exp 1", res); end
        n_checks++; if (insert_count_o !== 16'd2) begin n_fails++; $display("FAIL ins2_count: got %0d exp 2", insert_count_o); end
        do_op(BLOOM_CHECK, 32'h12345678, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h1)    begin n_fails++; $display("FAIL chk_hit_result: got %h exp 1", res); end
        n_checks++; if (insert_count_o !== 16'd2) begin n_fails++; $display("FAIL chk_hit_count: got %0d exp 2", insert_count_o); end
    endtask

    task automatic test_clear();
        int lat; logic [31:0] res; logic err;
        do_op(BLOOM_CLEAR, 32'h0, 32'h0, lat, res, err);
        n_checks++; if (lat !== 17)       begin n_fails++; $display("FAIL clear_latency: got %0d exp 17", lat); end
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL clear_result: got %h exp 0", res); end
        n_checks++; if (err !== 1'b0)     begin n_fails++; $display("FAIL clear_err: got %b exp 0", err); end
        n_checks++; if (insert_count_o !== 16'd0) begin n_fails++; $display("FAIL clear_count: got %0d exp 0", insert_count_o); end
        do_op(BLOOM_CHECK, 32'h12345678, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL post_clear_check: got %h exp 0", res); end
    endtask

    task automatic test_salt();
        int lat; logic [31:0] res; logic err;
        do_op(BLOOM_CHECK, 32'h0, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL salt_pre_check: got %h exp 0", res); end
        do_op(BLOOM_INSERT, 32'hA5A5A5A5, 32'hA5A5A5A5, lat, res, err);
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL salt_insert_result: got %h exp 0", res); end
        n_checks++; if (insert_count_o !== 16'd1) begin n_fails++; $display("FAIL salt_insert_count: got %0d exp 1", insert_count_o); end
        do_op(BLOOM_CHECK, 32'h0, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h1)    begin n_fails++; $display("FAIL salt_check_hit: got %h exp 1", res); end
    endtask

    task automatic test_reserved_hold();
        int lat; logic [31:0] res; logic err;
        issue(BLOOM_RSVD, 32'hFFFFFFFF, 32'h0, lat, res, err);
        n_checks++; if (lat !== 1)        begin n_fails++; $display("FAIL rsvd_latency: got %0d exp 1", lat); end
        n_checks++; if (err !== 1'b1)     begin n_fails++; $display("FAIL rsvd_err: got %b exp 1", err); end
        n_checks++; if (res !== 32'h0)    begin n_fails++; $display("FAIL rsvd_result: got %h exp 0", res); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b1;
            req_op_i    = BLOOM_CLEAR;
            @(posedge clk_i); #1;
            n_checks++; if (rsp_valid_o !== 1'b1) begin n_fails++; $display("FAIL hold_valid[%0d]: got %b exp 1", i, rsp_valid_o); end
            n_checks++; if (rsp_err_o !== 1'b1)   begin n_fails++; $display("FAIL hold_err[%0d]: got %b exp 1", i, rsp_err_o); end
            n_checks++; if (rsp_result_o !== 32'h0) begin n_fails++; $display("FAIL hold_result[%0d]: got %h exp 0", i, rsp_result_o); end
            n_checks++; if (req_ready_o !== 1'b0) begin n_fails++; $display("FAIL hold_ready[%0d]: got %b exp 0", i, req_ready_o); end
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        finish_rsp();
        n_checks++; if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL post_rsp_ready: got %b exp 1", req_ready_o); end
        n_checks++; if (insert_count_o !== 16'd1) begin n_fails++; $display("FAIL rsvd_count: got %0d exp 1", insert_count_o); end
        do_op(BLOOM_CHECK, 32'h0, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h1)    begin n_fails++; $display("FAIL ignored_clear_check: got %h exp 1", res); end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++; if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL %s_ready: got %b exp 1", tag, req_ready_o); end
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL %s_valid: got %b exp 0", tag, rsp_valid_o); end
        n_checks++; if (busy_o !== 1'b0)      begin n_fails++; $display("FAIL %s_busy: got %b exp 0", tag, busy_o); end
        n_checks++; if (insert_count_o !== 16'd0) begin n_fails++; $display("FAIL %s_count: got %0d exp 0", tag, insert_count_o); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; logic err; logic seen;
        // Reset during the HASH phase of an INSERT (insert_count_o is 1 beforehand).
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = BLOOM_INSERT; req_key_i = 32'hDEADBEEF; req_salt_i = 32'h0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_hash");
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fails++; $display("FAIL rst_hash_dropped: got %b exp 0", seen); end
        do_op(BLOOM_CHECK, 32'hDEADBEEF, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h0) begin n_fails++; $display("FAIL rst_hash_check: got %h exp 0", res); end

        // Insert fully, then reset during CLEAR chunk 5.
        do_op(BLOOM_INSERT, 32'hDEADBEEF, 32'h0, lat, res, err);
        n_checks++; if (insert_count_o !== 16'd1) begin n_fails++; $display("FAIL rst_clr_pre_count: got %0d exp 1", insert_count_o); end
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = BLOOM_CLEAR;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_clear");
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op(BLOOM_CHECK, 32'hDEADBEEF, 32'h0, lat, res, err);
        n_checks++; if (res !== 32'h0) begin n_fails++; $display("FAIL rst_clear_check: got %h exp 0", res); end
        n_checks++; if (lat !== 4)     begin n_fails++; $display("FAIL rst_clear_check_latency: got %0d exp 4", lat); end
    endtask

    initial begin
        test_reset();
        test_check_empty();
        test_insert();
        test_clear();
        test_salt();
        test_reserved_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
